// File: rtl/io_input_responder_if.sv
// rtl/io_input_responder_if.sv - core-side request/response handshake for io_input_responder
interface io_input_responder_if;
    logic        input_flag;
    logic [31:0] user_input;
    logic        input_valid;
    logic        waiting;

    modport master (
        output input_flag,
        input  user_input,
        input  input_valid,
        input  waiting
    );

    modport slave (
        input  input_flag,
        output user_input,
        output input_valid,
        output waiting
    );
endinterface

// File: rtl/io_input_responder.sv
// rtl/io_input_responder.sv - debounced pushbutton / switch capture responder for the core input instruction
module io_input_responder #(
    parameter int DATA_W          = 15,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SIGN_EXT        = 0
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  insert_n,
    input  logic [DATA_W-1:0]     SW,
    output logic                  press_seen,
    io_input_responder_if.slave   bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DELIVER,
        S_RELEASE
    } state_t;

    logic              r_ins_s1;
    logic              r_ins_s2;
    logic [DATA_W-1:0] r_sw_s1;
    logic [DATA_W-1:0] r_sw_s2;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_press_seen;
    logic              r_press_rise;
    logic [31:0]       r_user_input;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_btn;
    logic [31:0]       w_ext;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_ins_s1 <= 1'b1;
            r_ins_s2 <= 1'b1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_ins_s1 <= insert_n;
            r_ins_s2 <= r_ins_s1;
            r_sw_s1  <= SW;
            r_sw_s2  <= r_sw_s1;
        end
    end

    assign w_btn = ~r_ins_s2;

    // Any single sample agreeing with the accepted level restarts the count, so
    // only DEBOUNCE_CYCLES consecutive disagreeing samples flip press_seen.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_press_seen <= 1'b0;
            r_press_rise <= 1'b0;
        end else if (w_btn != r_press_seen) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt        <= '0;
                r_press_seen <= w_btn;
                r_press_rise <= w_btn;
            end else begin
                r_cnt        <= r_cnt + CNT_W'(1);
                r_press_rise <= 1'b0;
            end
        end else begin
            r_cnt        <= '0;
            r_press_rise <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.input_flag && !r_press_seen) w_state_nxt = S_ARMED;
            // Withdrawal takes priority over a press arriving in the same cycle.
            S_ARMED:   if (!bus.input_flag)                 w_state_nxt = S_IDLE;
                       else if (r_press_rise)               w_state_nxt = S_CAPTURE;
            S_CAPTURE:                                      w_state_nxt = S_DELIVER;
            S_DELIVER:                                      w_state_nxt = S_RELEASE;
            S_RELEASE: if (!r_press_seen && !bus.input_flag) w_state_nxt = S_IDLE;
            default:                                        w_state_nxt = S_IDLE;
        endcase
    end

    generate
        if (SIGN_EXT != 0) begin : g_sext
            assign w_ext = {{(32-DATA_W){r_sw_s2[DATA_W-1]}}, r_sw_s2};
        end else begin : g_zext
            assign w_ext = {{(32-DATA_W){1'b0}}, r_sw_s2};
        end
    endgenerate

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_user_input <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_user_input <= w_ext;
        end
    end

    assign bus.user_input  = r_user_input;
    assign bus.input_valid = (r_state == S_DELIVER);
    assign bus.waiting     = (r_state == S_ARMED);
    assign press_seen      = r_press_seen;

endmodule

// File: tb/tb_io_input_responder.sv
// tb/tb_io_input_responder.sv - self-checking bench for io_input_responder (zero- and sign-extend instances)
module tb_io_input_responder;

    logic        CLK = 1'b0;
    logic        reset;
    logic        insert_n;
    logic [14:0] SW;
    logic        ps0, ps1;
    int          checks   = 0;
    int          failures = 0;
    int          vcnt0    = 0;
    int          vcnt1    = 0;

    io_input_responder_if u_if0();
    io_input_responder_if u_if1();

    io_input_responder #(.DATA_W(15), .DEBOUNCE_CYCLES(4), .SIGN_EXT(0)) dut0 (
        .CLK(CLK), .reset(reset), .insert_n(insert_n), .SW(SW), .press_seen(ps0), .bus(u_if0.slave)
    );
    io_input_responder #(.DATA_W(15), .DEBOUNCE_CYCLES(4), .SIGN_EXT(1)) dut1 (
        .CLK(CLK), .reset(reset), .insert_n(insert_n), .SW(SW), .press_seen(ps1), .bus(u_if1.slave)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (u_if0.input_valid) vcnt0++;
        if (u_if1.input_valid) vcnt1++;
    end

    typedef struct {
        logic [14:0] sw;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic set_flag(input logic v);
        u_if0.input_flag = v;
        u_if1.input_flag = v;
    endtask

    task automatic do_press(input int low);
        insert_n = 1'b0;
        repeat (low) tick();
        insert_n = 1'b1;
        repeat (12) tick();
    endtask

    initial begin
        int lat, c0, c1, any_ps;

        vecs[0] = '{15'h1234, 32'h0000_1234, 32'h0000_1234};
        vecs[1] = '{15'h4001, 32'h0000_4001, 32'hFFFF_C001};
        vecs[2] = '{15'h7FFF, 32'h0000_7FFF, 32'hFFFF_FFFF};
        vecs[3] = '{15'h0000, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{15'h2AAA, 32'h0000_2AAA, 32'h0000_2AAA};
        vecs[5] = '{15'h5555, 32'h0000_5555, 32'hFFFF_D555};

        reset = 1'b0; insert_n = 1'b1; SW = '0; set_flag(1'b0);
        repeat (3) tick();
        chk("rst_user_input", u_if0.user_input, 32'h0);
        chk("rst_input_valid", {31'h0, u_if0.input_valid}, 32'h0);
        chk("rst_waiting", {31'h0, u_if0.waiting}, 32'h0);
        chk("rst_press_seen", {31'h0, ps0}, 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            SW = vecs[i].sw;
            set_flag(1'b1);
            tick(); tick();
            chk("vec_waiting", {31'h0, u_if0.waiting}, 32'h1);
            c0 = vcnt0; c1 = vcnt1; lat = 0;
            insert_n = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                tick();
                if (u_if0.input_valid && lat == 0) lat = k;
                if (k == 10) insert_n = 1'b1;
            end
            repeat (10) tick();
            set_flag(1'b0);
            repeat (3) tick();
            chk("vec_latency", lat, 8);
            chk("vec_pulses0", vcnt0 - c0, 1);
            chk("vec_pulses1", vcnt1 - c1, 1);
            chk("vec_user_zext", u_if0.user_input, vecs[i].exp0);
            chk("vec_user_sext", u_if1.user_input, vecs[i].exp1);
            chk("vec_idle_waiting", {31'h0, u_if0.waiting}, 32'h0);
        end

        // bounce rejection
        SW = 15'h0ABC;
        set_flag(1'b1);
        tick(); tick();
        c0 = vcnt0; any_ps = 0;
        for (int i = 0; i < 20; i++) begin
            insert_n = 1'b0;
            repeat ((i % 3) + 1) begin tick(); if (ps0) any_ps = 1; end
            insert_n = 1'b1;
            repeat (2) begin tick(); if (ps0) any_ps = 1; end
        end
        repeat (4) begin tick(); if (ps0) any_ps = 1; end
        chk("bounce_press_seen", any_ps, 0);
        chk("bounce_no_pulse", vcnt0 - c0, 0);
        chk("bounce_still_armed", {31'h0, u_if0.waiting}, 32'h1);
        do_press(6);
        chk("bounce_real_press", vcnt0 - c0, 1);
        chk("bounce_capture", u_if0.user_input, 32'h0000_0ABC);
        set_flag(1'b0);
        repeat (3) tick();

        // held-button guard
        c0 = vcnt0;
        insert_n = 1'b0;
        repeat (10) tick();
        chk("held_press_seen", {31'h0, ps0}, 32'h1);
        set_flag(1'b1);
        repeat (5) tick();
        chk("held_waiting", {31'h0, u_if0.waiting}, 32'h0);
        chk("held_no_pulse", vcnt0 - c0, 0);
        insert_n = 1'b1;
        repeat (10) tick();
        chk("held_rearmed", {31'h0, u_if0.waiting}, 32'h1);
        do_press(6);
        chk("held_one_pulse", vcnt0 - c0, 1);
        set_flag(1'b0);
        repeat (3) tick();

        // withdrawal and re-arm
        c0 = vcnt0;
        set_flag(1'b1); tick(); tick();
        set_flag(1'b0); tick(); tick();
        do_press(6);
        chk("withdraw_no_pulse", vcnt0 - c0, 0);
        chk("withdraw_waiting", {31'h0, u_if0.waiting}, 32'h0);
        set_flag(1'b1); tick(); tick();
        do_press(6);
        chk("rearm_pulse", vcnt0 - c0, 1);
        do_press(6);
        chk("same_flag_no_second", vcnt0 - c0, 1);
        chk("release_waiting", {31'h0, u_if0.waiting}, 32'h0);
        set_flag(1'b0); tick(); tick();
        set_flag(1'b1); tick(); tick();
        do_press(6);
        chk("toggle_flag_pulse", vcnt0 - c0, 2);
        set_flag(1'b0);
        repeat (3) tick();

        // asynchronous reset while in CAPTURE
        SW = 15'h7FFF;
        set_flag(1'b1); tick(); tick();
        c0 = vcnt0;
        insert_n = 1'b0;
        repeat (7) tick();
        reset = 1'b0;
        #1;
        chk("arst_user_input", u_if0.user_input, 32'h0);
        chk("arst_user_input_sext", u_if1.user_input, 32'h0);
        chk("arst_input_valid", {31'h0, u_if0.input_valid}, 32'h0);
        chk("arst_press_seen", {31'h0, ps0}, 32'h0);
        insert_n = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (15) tick();
        chk("arst_no_pulse", vcnt0 - c0, 0);
        chk("arst_user_held", u_if0.user_input, 32'h0);
        chk("arst_rearmed", {31'h0, u_if0.waiting}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_input_responder.md
Name: io_input_responder

Overview:
- Responder side of the processor's user-input handshake.
- The core raises input_flag while it waits on an input instruction. This block debounces the raw insert pushbutton and synchronizes the SW bank.
- On a confirmed press it latches the switch value, extends it to 32 bits and returns it with a one-cycle input_valid pulse.
- It sits between the board pins and the IO unit. It replaces direct use of the insert and SW pins.

Parameters:
- DATA_W, 15, width of the switch bank.
- DEBOUNCE_CYCLES, 50000, number of consecutive stable synchronized samples needed to accept a button level change (1 ms at 50 MHz).
- SIGN_EXT, 0, 1 = sign-extend SW[DATA_W-1] into user_input; 0 = zero-extend.

Ports:
- CLK, input, 1: the block's single clock.
- reset, input, 1: asynchronous, active-low reset.
- input_flag, input, 1: core requests a value; level, held until input_valid is seen.
- insert_n, input, 1: raw pushbutton, active-low, asynchronous to CLK.
- SW, input, DATA_W: raw switches, asynchronous.
- user_input, output, 32: captured value; held stable until the next capture.
- input_valid, output, 1: one-cycle pulse, user_input valid in the same cycle.
- waiting, output, 1: high in ARMED (drives an LED prompt).
- press_seen, output, 1: debounced button level (1 = pressed), for status/debug.

Behaviour:
- Reset (reset = 0, async):
  - user_input = 0, input_valid = 0, waiting = 0, press_seen = 0.
  - Synchronizer flops are set to released (insert_n sync = 1) and SW sync = 0.
  - Debounce counter = 0, FSM = IDLE.
  - Release is synchronous to CLK and takes effect at the first rising edge with reset = 1.
- Synchronization:
  - insert_n and SW each pass through two flops before any use.
  - Capture uses the synchronized SW only.
- Debounce:
  - The counter (width clog2(DEBOUNCE_CYCLES+1)) increments while the synchronized button differs from press_seen. It clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, press_seen toggles and the counter clears.
  - press_rise is a single-cycle strobe on the 0->1 toggle of press_seen.
  - Glitches shorter than DEBOUNCE_CYCLES never toggle press_seen.
  - Latency from a stable pin change to the press_seen toggle = 2 + DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, ARMED, CAPTURE, DELIVER, RELEASE.
  - IDLE: waiting = 0. If input_flag = 1 and press_seen = 0, go to ARMED. If input_flag = 1 and press_seen = 1 (button already held), stay in IDLE until release. A stale press is never captured.
  - ARMED: waiting = 1. On press_rise, go to CAPTURE. If input_flag falls, go to IDLE with no pulse (request withdrawn).
  - CAPTURE: register user_input from the synchronized SW with the extension selected by SIGN_EXT. Go to DELIVER next cycle.
  - DELIVER: input_valid = 1 for exactly this cycle. Go to RELEASE.
  - RELEASE: stay until press_seen = 0 and input_flag = 0, then go to IDLE. A second request cannot complete on the same press.
- Latency: input_valid asserts 2 cycles after the press_rise cycle.
- Simultaneous events:
  - input_flag falling in the same cycle as press_rise while in ARMED: the withdrawal wins, go to IDLE, no capture.
  - input_flag held high through RELEASE: no new pulse until it drops and rises again.
- SW changing during CAPTURE is allowed. The value sampled at the CAPTURE edge is delivered.
- Reset mid-operation (any state) returns to the reset values and drops any pending capture. No input_valid is emitted after reset deasserts until a full new handshake completes.

Test Plan (DEBOUNCE_CYCLES = 4 for simulation):
1. Basic capture:
   - Stimulus: SW = 15'h1234, raise input_flag, hold insert_n low for 10 cycles.
   - Required: waiting = 1; input_valid pulses once at 2 + 4 + 2 cycles after the pin falls; user_input = 32'h00001234.
2. Sign extension:
   - Stimulus: SIGN_EXT = 1, SW = 15'h4001, press.
   - Required: user_input = 32'hFFFFC001. With SIGN_EXT = 0 the same input gives 32'h00004001.
3. Bounce rejection:
   - Stimulus: in ARMED, toggle insert_n with low pulses of 1–3 cycles, 20 times.
   - Required: press_seen stays 0; no input_valid. A following 6-cycle low produces exactly one pulse.
4. Held-button guard:
   - Stimulus: hold insert_n low, then raise input_flag.
   - Required: FSM stays IDLE, waiting = 0, no pulse. After release plus a new press, exactly one pulse.
5. Withdrawal and re-arm:
   - Stimulus: raise input_flag, drop it before any press, then press.
   - Required: no pulse. After capture, keeping input_flag high and pressing again gives no second pulse until input_flag toggles.
6. Async reset:
   - Stimulus: assert reset in CAPTURE with SW = 15'h7FFF.
   - Required: user_input = 0 and input_valid = 0 immediately, FSM = IDLE; no pulse after reset releases.
